rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
//  Shares the single-port, combinational-read instruction ROM between two requesters:
//  port 0 = pipeline instruction fetch, port 1 = data/debug reader (UART loader, loads).
//  Round-robin arbitration with a bounded lock for port-1 bursts.
//  Registered ROM address, response one cycle after grant.
//  Byte-address to word-index translation, with alignment/range error flagging.
//  Sits between the IF stage / debug master and the ROM's A/RD pins.
// PARAMETERS
//  DATA_WIDTH  32  ROM word width
//  ADDR_WIDTH  10  ROM word-address width (depth = 2**ADDR_WIDTH)
//  MAX_LOCK    16  max consecutive cycles port 1 may hold the lock (>=1)
// PORTS
//  clk     in   1           system clock, rising edge
//  rst     in   1           synchronous reset, active-high
//  req0    in   1           port 0 request; hold with addr0 stable until gnt0
//  addr0   in   32          port 0 byte address
//  gnt0    out  1           port 0 grant (combinational, same cycle as req0)
//  rvalid0 out  1           port 0 response valid (registered)
//  rdata0  out  DATA_WIDTH  port 0 read data, qualified by rvalid0
//  err0    out  1           port 0 error response, qualified by rvalid0
//  req1, addr1, gnt1, rvalid1, rdata1, err1   same as port 0, for port 1
//  lock1   in   1           port 1 requests the ROM be held after this grant
//  rom_a   out  ADDR_WIDTH  ROM word address (registered)
//  rom_rd  in   DATA_WIDTH  ROM read data (combinational from rom_a)
// BEHAVIOUR
//  Reset: state=ARB, last=1 (port 0 wins first tie), lock_cnt=0, rom_a=0, rvalid0/1=0, err0/1=0.
//   gnt0/1 and rdata0/1 evaluate to 0 while rst is high.
//  rst has priority over every other event. Reset mid-transfer drops the pending response.
//  Grant, state ARB:
//   - only req0 -> gnt0. Only req1 -> gnt1.
//   - both -> grant the port != last.
//   - at most one grant per cycle. On any grant, last <= granted port.
//  Grant, state LOCKED: gnt1 = req1; gnt0 = 0.
//  Address capture, at the edge ending grant cycle N:
//   - rom_a <= addr[ADDR_WIDTH+1:2] of the granted port.
//   - rvalidX <= 1 for that port only.
//   - errX <= (addr[1:0]!=0) | (addr[31:ADDR_WIDTH+2]!=0).
//   - no grant -> rom_a holds, rvalid0/1 <= 0.
//  Response, cycle N+1: rdataX = (rvalidX & ~errX) ? rom_rd : 0.
//   - latency is exactly 1 cycle.
//   - back-to-back grants give one response per cycle (full throughput).
//   - the error response still consumes the slot, and rom_a is still updated.
//  FSM:
//   - ARB -> LOCKED: gnt1 & lock1. Set lock_cnt=1.
//   - LOCKED -> ARB: gnt1 & ~lock1 (final beat), or ~req1 (master released).
//   - LOCKED -> ARB, timeout: lock_cnt==MAX_LOCK. Force last=1 so a waiting req0 wins the next cycle.
//   - LOCKED otherwise: lock_cnt increments every cycle (granted or not) and saturates at MAX_LOCK.
//   - the timeout cycle may still grant req1. The exit takes effect the next cycle.
//   - lock0 does not exist. Port 0 can never lock.
//  Fairness: in ARB with both requesting continuously, grants alternate 0,1,0,1.
//   - port 0 waits at most MAX_LOCK+1 cycles.
// TESTING (bench ROM model: rom[i] = 32'hA000_0000 + i)
//  1 Reset: rst=1 with req0=req1=1 for 2 cycles -> gnt0=gnt1=0, rvalid*=0, rom_a=0.
//    First cycle after reset: gnt0=1.
//  2 Single fetch: req0, addr0=0x10 -> gnt0 in cycle N, rom_a=4.
//    Cycle N+1: rvalid0=1, rdata0=0xA0000004, err0=0.
//  3 Contention: req0 and req1 held 6 cycles, addr0=0x0, addr1=0x8 -> grants 0,1,0,1,0,1.
//    Responses 0xA0000000 and 0xA0000002 alternate one cycle later.
//  4 Errors: addr0=0x6 -> rvalid0=1, err0=1, rdata0=0.
//    addr1=0x1000 with ADDR_WIDTH=10 -> err1=1, rdata1=0.
//  5 Lock: req1 with lock1=1 for 4 grants, then lock1=0, while req0 held -> gnt0=0 for those 5 grants.
//    gnt0=1 the cycle after the unlocked beat.
//  6 Lock timeout + mid-reset: lock1 held, MAX_LOCK=4 -> gnt0=1 at cycle 5 after lock entry.
//    Repeat with rst pulsed while LOCKED -> state ARB, rvalid1=0 next cycle.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//   Shares a single-port, combinational-read instruction ROM between two
//   requesters: port 0 (instruction fetch) and port 1 (data/debug reader).
//   Round-robin arbitration in the normal state; port 1 may hold the ROM
//   through a bounded lock. The ROM address is registered, so the response
//   for a grant in cycle N appears in cycle N+1. Byte addresses are turned
//   into word indices, and misaligned or out-of-range addresses return an
//   error response instead of data.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   req0/addr0         port 0 request and byte address (hold until gnt0)
//   gnt0               port 0 grant, combinational in the request cycle
//   rvalid0/rdata0     port 0 response one cycle after the grant
//   err0               port 0 error flag, qualified by rvalid0
//   req1/addr1/gnt1/rvalid1/rdata1/err1   same for port 1
//   lock1              port 1 asks to keep the ROM after this grant
//   rom_a              registered ROM word address
//   rom_rd             ROM read data (combinational from rom_a)
//   dbg_locked         high while the arbiter is in the LOCKED state
//
// Handshake: a port asserts reqX and holds addrX stable until the cycle in
//   which gntX is high; that cycle is the transfer. rvalidX follows exactly
//   one cycle later, with either rdataX or errX. There is no backpressure on
//   the response side.

module rom_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_LOCK   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [31:0]           addr0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  err0,
    input  logic                  req1,
    input  logic [31:0]           addr1,
    input  logic                  lock1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  err1,
    output logic [ADDR_WIDTH-1:0] rom_a,
    input  logic [DATA_WIDTH-1:0] rom_rd,
    output logic                  dbg_locked
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0] LOCK_ONE = CNT_W'(1);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic                  last_q, last_d;      // port granted most recently
    logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;
    logic [ADDR_WIDTH-1:0] rom_a_q, rom_a_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic                  err0_q, err0_d;
    logic                  err1_q, err1_d;

    logic                  gnt0_c, gnt1_c;
    logic                  bad0, bad1;

    // Misaligned byte address, or any bit set above the ROM's word range.
    assign bad0 = (addr0[1:0] != 2'b00) || (addr0[31:ADDR_WIDTH+2] != '0);
    assign bad1 = (addr1[1:0] != 2'b00) || (addr1[31:ADDR_WIDTH+2] != '0);

    // Grant decode. At most one grant per cycle; nothing is granted in reset.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_ARB: begin
                    if (req0 && req1) begin
                        // Tie goes to the port that did not win last time.
                        if (last_q) gnt0_c = 1'b1;
                        else        gnt1_c = 1'b1;
                    end else if (req0) begin
                        gnt0_c = 1'b1;
                    end else if (req1) begin
                        gnt1_c = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    gnt1_c = req1;
                end
                default: begin
                    gnt0_c = 1'b0;
                    gnt1_c = 1'b0;
                end
            endcase
        end
    end

    // Next-state logic for the arbitration FSM and the lock counter.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;

        if (gnt0_c) last_d = 1'b0;
        if (gnt1_c) last_d = 1'b1;

        case (state_q)
            ST_ARB: begin
                if (gnt1_c && lock1) begin
                    state_d    = ST_LOCKED;
                    lock_cnt_d = LOCK_ONE;
                end
            end
            ST_LOCKED: begin
                if (lock_cnt_q == LOCK_MAX) begin
                    // Timeout: this cycle may still serve port 1, but port 0
                    // must win the first tie after the lock is broken.
                    state_d    = ST_ARB;
                    last_d     = 1'b1;
                    lock_cnt_d = '0;
                end else if ((gnt1_c && !lock1) || !req1) begin
                    state_d    = ST_ARB;
                    lock_cnt_d = '0;
                end else begin
                    // Counts every locked cycle, granted or not.
                    lock_cnt_d = lock_cnt_q + LOCK_ONE;
                end
            end
            default: begin
                state_d    = ST_ARB;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Address capture and response flags for the granted port. An error
    // transfer still moves rom_a and still occupies its response slot.
    always_comb begin
        rom_a_d   = rom_a_q;
        rvalid0_d = gnt0_c;
        rvalid1_d = gnt1_c;
        err0_d    = gnt0_c && bad0;
        err1_d    = gnt1_c && bad1;
        if (gnt0_c) begin
            rom_a_d = addr0[ADDR_WIDTH+1:2];
        end else if (gnt1_c) begin
            rom_a_d = addr1[ADDR_WIDTH+1:2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ARB;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            rom_a_q    <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            rom_a_q    <= rom_a_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
        end
    end

    assign gnt0       = gnt0_c;
    assign gnt1       = gnt1_c;
    assign rvalid0    = rvalid0_q;
    assign rvalid1    = rvalid1_q;
    assign err0       = err0_q;
    assign err1       = err1_q;
    assign rom_a      = rom_a_q;
    assign dbg_locked = (state_q == ST_LOCKED);

    // Data is forced to zero unless a good response is being returned, and
    // while reset is held.
    assign rdata0 = (!rst && rvalid0_q && !err0_q) ? rom_rd : '0;
    assign rdata1 = (!rst && rvalid1_q && !err1_q) ? rom_rd : '0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk;
  logic          rst;
  logic          req0, req1, lock1;
  logic [31:0]   addr0, addr1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic          err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] rom_a;
  logic [DW-1:0] rom_rd;
  logic          dbg_locked;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: rom[i] = A000_0000 + i
  assign rom_rd = 32'hA000_0000 + {22'b0, rom_a};

  rom_port_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MAX_LOCK  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .addr0     (addr0),
    .gnt0      (gnt0),
    .rvalid0   (rvalid0),
    .rdata0    (rdata0),
    .err0      (err0),
    .req1      (req1),
    .addr1     (addr1),
    .lock1     (lock1),
    .gnt1      (gnt1),
    .rvalid1   (rvalid1),
    .rdata1    (rdata1),
    .err1      (err1),
    .rom_a     (rom_a),
    .rom_rd    (rom_rd),
    .dbg_locked(dbg_locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_gnt(input string tag, input logic e0, input logic e1);
    #1;
    check({tag, ".gnt0"}, {31'b0, gnt0}, {31'b0, e0});
    check({tag, ".gnt1"}, {31'b0, gnt1}, {31'b0, e1});
  endtask

  initial begin
    logic e0;
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; lock1 = 1'b0;
    addr0 = 32'h0; addr1 = 32'h8;

    // 1: reset with both requesting
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst.gnt0", {31'b0, gnt0}, 32'd0);
      check("rst.gnt1", {31'b0, gnt1}, 32'd0);
      check("rst.rvalid0", {31'b0, rvalid0}, 32'd0);
      check("rst.rvalid1", {31'b0, rvalid1}, 32'd0);
      check("rst.rom_a", {22'b0, rom_a}, 32'd0);
      check("rst.rdata0", rdata0, 32'd0);
    end
    rst = 1'b0;

    // 3: contention, first tie goes to port 0, then alternate
    for (int i = 0; i < 6; i++) begin
      e0 = (i % 2 == 0);
      check_gnt("cont", e0, !e0);
      step();
      check("cont.rvalid0", {31'b0, rvalid0}, {31'b0, e0});
      check("cont.rvalid1", {31'b0, rvalid1}, {31'b0, !e0});
      check("cont.rdata0", rdata0, e0 ? 32'hA000_0000 : 32'h0);
      check("cont.rdata1", rdata1, e0 ? 32'h0 : 32'hA000_0002);
      check("cont.rom_a", {22'b0, rom_a}, e0 ? 32'd0 : 32'd2);
    end
    req0 = 1'b0; req1 = 1'b0;
    check_gnt("idle", 1'b0, 1'b0);
    step();
    check("idle.rvalid0", {31'b0, rvalid0}, 32'd0);
    check("idle.rvalid1", {31'b0, rvalid1}, 32'd0);
    check("idle.rom_a_hold", {22'b0, rom_a}, 32'd2);

    // 2: single fetch
    req0 = 1'b1; addr0 = 32'h10;
    check_gnt("fetch", 1'b1, 1'b0);
    step();
    check("fetch.rom_a", {22'b0, rom_a}, 32'd4);
    check("fetch.rvalid0", {31'b0, rvalid0}, 32'd1);
    check("fetch.rdata0", rdata0, 32'hA000_0004);
    check("fetch.err0", {31'b0, err0}, 32'd0);

    // 4: misaligned on port 0, out of range on port 1
    addr0 = 32'h6;
    check_gnt("mis", 1'b1, 1'b0);
    step();
    check("mis.rvalid0", {31'b0, rvalid0}, 32'd1);
    check("mis.err0", {31'b0, err0}, 32'd1);
    check("mis.rdata0", rdata0, 32'd0);
    check("mis.rom_a", {22'b0, rom_a}, 32'd1);
    req0 = 1'b0; req1 = 1'b1; addr1 = 32'h1000;
    check_gnt("oor", 1'b0, 1'b1);
    step();
    check("oor.rvalid1", {31'b0, rvalid1}, 32'd1);
    check("oor.err1", {31'b0, err1}, 32'd1);
    check("oor.rdata1", rdata1, 32'd0);
    check("oor.rom_a", {22'b0, rom_a}, 32'd0);
    check("oor.rvalid0", {31'b0, rvalid0}, 32'd0);

    // 5: four locked grants then an unlocked beat while port 0 waits
    addr1 = 32'h20; addr0 = 32'h0C;
    for (int k = 0; k < 5; k++) begin
      req0 = (k > 0);
      lock1 = (k < 4);
      check_gnt("lock", 1'b0, 1'b1);
      step();
      check("lock.rvalid1", {31'b0, rvalid1}, 32'd1);
      check("lock.rdata1", rdata1, 32'hA000_0008);
      check("lock.err1", {31'b0, err1}, 32'd0);
    end
    check_gnt("unlock", 1'b1, 1'b0);
    check("unlock.state", {31'b0, dbg_locked}, 32'd0);
    step();
    check("unlock.rdata0", rdata0, 32'hA000_0003);

    // short lock ended by lock1 dropping
    lock1 = 1'b1;
    check_gnt("slock.entry", 1'b0, 1'b1);
    step();
    check("slock.state", {31'b0, dbg_locked}, 32'd1);
    lock1 = 1'b0;
    check_gnt("slock.last", 1'b0, 1'b1);
    step();
    check_gnt("slock.after", 1'b1, 1'b0);
    step();

    // lock ended by port 1 releasing its request
    lock1 = 1'b1;
    check_gnt("rel.entry", 1'b0, 1'b1);
    step();
    req1 = 1'b0; lock1 = 1'b0;
    check_gnt("rel.locked", 1'b0, 1'b0);
    step();
    check("rel.rvalid1", {31'b0, rvalid1}, 32'd0);
    check_gnt("rel.after", 1'b1, 1'b0);
    step();

    // 6: lock timeout with MAX_LOCK=4, port 0 wins on cycle 5
    req1 = 1'b1; lock1 = 1'b1;
    check_gnt("to.entry", 1'b0, 1'b1);
    step();
    for (int c = 1; c <= 4; c++) begin
      check_gnt("to.locked", 1'b0, 1'b1);
      check("to.state", {31'b0, dbg_locked}, 32'd1);
      step();
    end
    check_gnt("to.cycle5", 1'b1, 1'b0);
    check("to.state5", {31'b0, dbg_locked}, 32'd0);
    step();

    // re-enter the lock, then reset while LOCKED
    check_gnt("mrst.entry", 1'b0, 1'b1);
    step();
    check("mrst.locked", {31'b0, dbg_locked}, 32'd1);
    rst = 1'b1;
    check_gnt("mrst.during", 1'b0, 1'b0);
    check("mrst.rdata1", rdata1, 32'd0);
    step();
    check("mrst.state", {31'b0, dbg_locked}, 32'd0);
    check("mrst.rvalid1", {31'b0, rvalid1}, 32'd0);
    check("mrst.rom_a", {22'b0, rom_a}, 32'd0);
    rst = 1'b0;
    check_gnt("mrst.after", 1'b1, 1'b0);
    step();
    check("mrst.rdata0", rdata0, 32'hA000_0003);
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
